// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the byte-stream input handshake, the memory write port and the
//   processor control/status lines of the program loader.
//   Parameter:
//     ADDR_W     memory word-address width (must match the loader instance)
//   Signals:
//     in_data    stream byte from the host
//     in_valid   in_data valid
//     in_ready   loader can accept a byte
//     mem_we     one-cycle memory write strobe
//     mem_addr   word address of the write
//     mem_wdata  word to write
//     cpu_hold   keeps the processor stalled while high
//     cpu_start  one-cycle processor restart pulse
//     done       last frame loaded successfully (sticky)
//     error      last frame failed its checksum (sticky)
//   Modports:
//     master     the loader (drives memory and processor control)
//     slave      the host/memory/processor side
`timescale 1ns/1ps

interface prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic              done;
  logic              error;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, cpu_start, done, error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, cpu_start, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program loader. Receives frames of the form
//     HDR_BYTE, start address, word count N, 4*N data bytes (MSB first)
//     [, checksum byte]
//   assembles big-endian 32-bit words and writes them one at a time into the
//   processor memory, holding the processor stalled until the frame is done.
//   Parameters:
//     ADDR_W    memory word-address width; write address wraps modulo 2^ADDR_W
//     HDR_BYTE  frame start marker
//   Ports:
//     clk1      system clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       prog_loader_if.master (stream in, memory write, cpu control)
//   Build option:
//     PROG_LOADER_CHECKSUM_EN  when defined, a checksum byte (XOR of address,
//     count and all data bytes) follows the payload and a mismatch sets error.
//     When undefined there is no checksum byte and error is tied low.
`timescale 1ns/1ps

module prog_loader #(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input logic           clk1,
  input logic           rst_n,
  prog_loader_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        state;
  logic [1:0]        bidx;
  logic [7:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              hold_q;
  logic              start_q;
  logic              done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic              error_q;
  logic [7:0]        csum;
`endif

  logic accept;
  logic is_hdr;

  assign accept = bus.in_valid && bus.in_ready;
  assign is_hdr = (bus.in_data == HDR_BYTE);

  // No back-pressure source exists yet; every state takes a byte per cycle.
  assign bus.in_ready  = 1'b1;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.cpu_start = start_q;
  assign bus.done      = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

  // Frame parser. wdata_q doubles as the shift register: the byte that
  // arrives while mem_we is high shifts in on the edge that ends the strobe,
  // so the word being written is stable for the whole write cycle and
  // back-to-back bytes are never lost. The address advances on the edge
  // that ends each write strobe.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bidx    <= 2'd0;
      wcnt    <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      error_q <= 1'b0;
      csum    <= 8'd0;
`endif
    end else begin
      we_q    <= 1'b0;
      start_q <= 1'b0;
      if (we_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (accept && is_hdr) begin
            state <= S_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum  <= 8'd0;
`endif
          end
        end

        S_ADDR: begin
          if (accept) begin
            addr_q <= ADDR_W'(bus.in_data);
            state  <= S_COUNT;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum   <= csum ^ bus.in_data;
`endif
          end
        end

        S_COUNT: begin
          if (accept) begin
            wcnt <= bus.in_data;
            bidx <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            if (bus.in_data == 8'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state   <= S_CSUM;
`else
              state   <= S_DONE;
              start_q <= 1'b1;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
`ifndef PROG_LOADER_CHECKSUM_EN
          // wcnt==0 here means the last word's strobe is out this cycle:
          // release the processor on the following edge, unless the host
          // already starts another frame.
          if (wcnt == 8'd0) begin
            if (accept && is_hdr) begin
              state <= S_ADDR;
            end else begin
              state   <= S_DONE;
              start_q <= 1'b1;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else
`endif
          if (accept) begin
            wdata_q <= {wdata_q[23:0], bus.in_data};
            bidx    <= bidx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.in_data;
`endif
            if (bidx == 2'd3) begin
              we_q <= 1'b1;
              wcnt <= wcnt - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
              if (wcnt == 8'd1) begin
                state <= S_CSUM;
              end
`endif
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (bus.in_data == csum) begin
              state   <= S_DONE;
              start_q <= 1'b1;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
              error_q <= 1'b0;
            end else begin
              state   <= S_ERR;
              done_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERR: begin
          // A new header stalls the processor again and clears the status.
          if (accept && is_hdr) begin
            state   <= S_ADDR;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            error_q <= 1'b0;
            csum    <= 8'd0;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
